// File: rtl/stack_data_ram.sv
// Data-stack storage array beside the stack pointer: combinational TOS/NOS reads,
// push/result writes on the pointer's clock edge, occupancy tracking and sticky error flags.
module stack_data_ram #(
    parameter int REG_BITS  = 32,
    parameter int ADDR_BITS = 6,
    parameter int DEPTH     = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_BITS-1:0]  SP_in,
    input  logic [1:0]           StackUpdateMode,
    input  logic [REG_BITS-1:0]  PushData,
    input  logic [REG_BITS-1:0]  ResultData,
    input  logic                 WriteTop,
    input  logic                 ErrClear,
    output logic [REG_BITS-1:0]  TOS_out,
    output logic [REG_BITS-1:0]  NOS_out,
    output logic [ADDR_BITS:0]   Depth_out,
    output logic                 Overflow,
    output logic                 Underflow
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_PUSH = 2'b01,
        MODE_POP2 = 2'b10,
        MODE_POP1 = 2'b11
    } mode_e;

    localparam logic [ADDR_BITS-1:0] IDX_ONE   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0]   CNT_TWO   = (ADDR_BITS+1)'(2);
    localparam logic [ADDR_BITS:0]   DEPTH_MAX = (ADDR_BITS+1)'(DEPTH);

    if (DEPTH != 2**ADDR_BITS) begin : g_depth_check
        $error("stack_data_ram: DEPTH must equal 2**ADDR_BITS");
    end

    logic [REG_BITS-1:0]  mem [DEPTH];
    logic [ADDR_BITS:0]   depth_q, depth_d;
    logic [ADDR_BITS-1:0] idx, wr_idx;
    logic [REG_BITS-1:0]  wr_data;
    logic                 wr_en, ovf_set, unf_set;
    logic                 overflow_q, underflow_q;
    mode_e                mode;

    assign mode = mode_e'(StackUpdateMode);
    assign idx  = SP_in[ADDR_BITS-1:0];

    // Index arithmetic wraps naturally in ADDR_BITS, so SP=0 reads NOS from DEPTH-1.
    assign TOS_out   = mem[idx];
    assign NOS_out   = mem[idx - IDX_ONE];
    assign Depth_out = depth_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_data = ResultData;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (mode)
            MODE_PUSH: begin
                if (depth_q < DEPTH_MAX) begin
                    wr_en   = 1'b1;
                    wr_idx  = idx + IDX_ONE;
                    wr_data = PushData;
                    depth_d = depth_q + CNT_ONE;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            MODE_POP1: begin
                if (depth_q >= CNT_TWO) begin
                    wr_en   = 1'b1;
                    wr_idx  = idx - IDX_ONE;
                    depth_d = depth_q - CNT_ONE;
                end else begin
                    unf_set = 1'b1;
                end
            end
            MODE_POP2: begin
                if (depth_q >= CNT_TWO) depth_d = depth_q - CNT_TWO;
                else                    unf_set = 1'b1;
            end
            MODE_HOLD: begin
                if (WriteTop) begin
                    if (depth_q != '0) wr_en   = 1'b1;
                    else               unf_set = 1'b1;
                end
            end
        endcase
    end

    // NOTE: the array has no reset; contents survive reset and only the write is gated by it.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) mem[wr_idx] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            overflow_q  <= ovf_set | (overflow_q  & ~ErrClear);
            underflow_q <= unf_set | (underflow_q & ~ErrClear);
        end
    end

endmodule

// File: tb/tb_stack_data_ram.sv
// Directed bench for stack_data_ram: a shadow array tracks expected contents and
// each step compares DUT outputs against hand-derived values.
module tb_stack_data_ram;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] SP_in;
    logic [1:0]  StackUpdateMode;
    logic [31:0] PushData;
    logic [31:0] ResultData;
    logic        WriteTop;
    logic        ErrClear;
    logic [31:0] TOS_out;
    logic [31:0] NOS_out;
    logic [6:0]  Depth_out;
    logic        Overflow;
    logic        Underflow;

    logic [31:0] mem_m [64];
    int          vectors    = 0;
    int          miscompares = 0;

    stack_data_ram dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .SP_in           (SP_in),
        .StackUpdateMode (StackUpdateMode),
        .PushData        (PushData),
        .ResultData      (ResultData),
        .WriteTop        (WriteTop),
        .ErrClear        (ErrClear),
        .TOS_out         (TOS_out),
        .NOS_out         (NOS_out),
        .Depth_out       (Depth_out),
        .Overflow        (Overflow),
        .Underflow       (Underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation for one clock edge, then return to an idle hold.
    task automatic op(input logic [1:0] mode, input logic [31:0] sp, input logic [31:0] pd,
                      input logic [31:0] rd, input logic wt, input logic ec, input logic rn);
        StackUpdateMode = mode;
        SP_in           = sp;
        PushData        = pd;
        ResultData      = rd;
        WriteTop        = wt;
        ErrClear        = ec;
        reset_n         = rn;
        @(posedge clk);
        #1;
        StackUpdateMode = 2'b00;
        WriteTop        = 1'b0;
        ErrClear        = 1'b0;
        reset_n         = 1'b1;
    endtask

    task automatic check_flags(input string tag, input logic [6:0] d, input logic o, input logic u);
        check({tag, ".depth"}, 32'(Depth_out), 32'(d));
        check({tag, ".ovf"},   32'(Overflow),  32'(o));
        check({tag, ".unf"},   32'(Underflow), 32'(u));
    endtask

    task automatic check_top(input string tag, input logic [31:0] sp);
        SP_in = sp;
        #1;
        check({tag, ".tos"}, TOS_out, mem_m[sp[5:0]]);
        check({tag, ".nos"}, NOS_out, mem_m[6'(sp[5:0] - 6'd1)]);
    endtask

    initial begin
        reset_n = 1'b0; SP_in = '0; StackUpdateMode = 2'b00;
        PushData = '0; ResultData = '0; WriteTop = 1'b0; ErrClear = 1'b0;
        op(2'b00, 0, 0, 0, 0, 0, 0);
        check_flags("init_reset", 7'd0, 1'b0, 1'b0);

        // Random fill: push at SP=i-1 lands in entry i.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = $urandom;
            mem_m[i] = d;
            op(2'b01, 32'((i + 63) % 64), d, 0, 0, 0, 1);
        end
        check_flags("full", 7'd64, 1'b0, 1'b0);

        // 65th push overflows and must not write entry 0.
        op(2'b01, 63, 32'hDEAD, 0, 0, 0, 1);
        check_flags("overflow", 7'd64, 1'b1, 1'b0);
        check_top("overflow_nowrite", 0);
        op(2'b00, 0, 0, 0, 0, 1, 1);
        check_flags("ovf_clear", 7'd64, 1'b0, 1'b0);

        // Reset during a push: depth clears, entry 11 untouched, held for 2 cycles.
        op(2'b01, 10, 32'hBEEF, 0, 0, 0, 0);
        op(2'b00, 10, 0, 0, 0, 0, 0);
        check_flags("reset_mid_push", 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) check_top("contents_kept", 32'(i));

        // WriteTop at depth 0 underflows without writing.
        op(2'b00, 20, 0, 32'h5555, 1, 0, 1);
        check_flags("wt_empty", 7'd0, 1'b0, 1'b1);
        check_top("wt_empty_nowrite", 20);
        // Clear and a new illegal pop in the same cycle: set wins.
        op(2'b11, 20, 0, 32'h6666, 0, 1, 1);
        check_flags("set_wins", 7'd0, 1'b0, 1'b1);
        check_top("pop1_empty_nowrite", 20);
        op(2'b00, 20, 0, 0, 0, 1, 1);
        check_flags("unf_clear", 7'd0, 1'b0, 1'b0);

        // Push/ALU sequence.
        op(2'b01, 5, 32'hA, 0, 0, 0, 1); mem_m[6] = 32'hA;
        op(2'b01, 6, 32'hB, 0, 0, 0, 1); mem_m[7] = 32'hB;
        check_flags("two_pushes", 7'd2, 1'b0, 1'b0);
        check_top("alu_operands", 7);
        check("alu_tos_literal", TOS_out, 32'hB);
        check("alu_nos_literal", NOS_out, 32'hA);
        op(2'b11, 7, 0, 32'h15, 0, 0, 1); mem_m[6] = 32'h15;
        check_flags("pop1", 7'd1, 1'b0, 1'b0);
        check_top("pop1_result", 6);
        check("pop1_tos_literal", TOS_out, 32'h15);

        // Pop-2 at depth 1 underflows and holds depth.
        op(2'b10, 6, 0, 0, 0, 0, 1);
        check_flags("pop2_short", 7'd1, 1'b0, 1'b1);
        op(2'b00, 6, 0, 0, 0, 1, 1);

        // Legal WriteTop overwrites the top entry.
        op(2'b00, 6, 0, 32'h77, 1, 0, 1); mem_m[6] = 32'h77;
        check_flags("wt_legal", 7'd1, 1'b0, 1'b0);
        check_top("wt_legal", 6);

        // WriteTop is ignored outside hold mode.
        op(2'b01, 6, 32'h99, 32'h1234, 1, 0, 1); mem_m[7] = 32'h99;
        check_flags("push_wt_ignored", 7'd2, 1'b0, 1'b0);
        check_top("push_wt_ignored", 7);

        // Legal pop-2 drops two entries without writing.
        op(2'b10, 7, 32'h3333, 32'h4444, 0, 0, 1);
        check_flags("pop2_legal", 7'd0, 1'b0, 1'b0);
        check_top("pop2_nowrite", 7);

        // Wrap: push at SP=63 lands in entry 0; NOS at SP=0 is entry 63.
        op(2'b01, 63, 32'h11, 0, 0, 0, 1); mem_m[0] = 32'h11;
        check_flags("wrap_push", 7'd1, 1'b0, 1'b0);
        check_top("wrap", 0);
        check("wrap_tos_literal", TOS_out, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
